// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      DATA  = 3'd1,
      CSUM  = 3'd2,
      RUN   = 3'd3,
      ERROR = 3'd4
   } state_t;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects little-endian bytes into 32-bit words; word/word_valid are presented
// combinationally on the byte that completes a word so the owner can register them.
module byte_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shreg_q, shreg_d;

   // Next byte counter and shift register; earlier bytes move toward bit 0.
   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (clear) begin
         cnt_d   = 2'd0;
         shreg_d = 24'd0;
      end else if (byte_en) begin
         cnt_d   = cnt_q + 2'd1;
         shreg_d = {byte_in, shreg_q[23:8]};
      end else begin
         cnt_d   = cnt_q;
         shreg_d = shreg_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= 2'd0;
         shreg_q <= 24'd0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

   assign word       = {byte_in, shreg_q};
   assign word_valid = byte_en && !clear && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot image loader: streams header + words into instruction memory and holds the CPU in reset until done.
// Optional feature macro IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit word-sum checksum check.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_DEPTH = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        reload,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset,
   output logic        done,
   output logic        error
);

   localparam int IDX_W = $clog2(MEM_DEPTH) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t POST_DATA = CSUM;
`else
   localparam state_t POST_DATA = RUN;
`endif

   state_t           state_q, state_d;
   logic [IDX_W-1:0] widx_q, widx_d;
   logic [IDX_W-1:0] n_q, n_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic             in_ready_q, in_ready_d;
   logic             cpu_reset_q, cpu_reset_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]      sum_q, sum_d;
`endif

   logic        byte_en;
   logic        asm_clear;
   logic [31:0] asm_word;
   logic        asm_valid;

   assign byte_en = in_valid && in_ready_q;

   byte_assembler u_asm (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (asm_clear),
      .byte_en    (byte_en),
      .byte_in    (in_data),
      .word       (asm_word),
      .word_valid (asm_valid)
   );

   // Sequencing reacts only to completed words; a partial word leaves everything frozen.
   always_comb begin
      state_d     = state_q;
      widx_d      = widx_q;
      n_d         = n_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      asm_clear   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
`endif
      case (state_q)
         HDR: begin
            if (!asm_valid) begin
               state_d = state_q;
            end else if (asm_word > 32'(MEM_DEPTH)) begin
               state_d = ERROR;
            end else if (asm_word == 32'd0) begin
               state_d = POST_DATA;
            end else begin
               n_d     = asm_word[IDX_W-1:0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (asm_valid) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = 32'({widx_q, 2'b00});
               mem_wdata_d = asm_word;
               widx_d      = widx_q + IDX_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d       = sum_q + asm_word;
`endif
               if (widx_q == n_q - IDX_W'(1)) begin
                  state_d = POST_DATA;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = state_q;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CSUM: begin
            if (!asm_valid) begin
               state_d = state_q;
            end else if (asm_word == sum_q) begin
               state_d = RUN;
            end else begin
               state_d = ERROR;
            end
         end
`endif
         RUN: begin
            if (reload) begin
               state_d   = HDR;
               widx_d    = '0;
               asm_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d     = 32'd0;
`endif
            end else begin
               state_d = RUN;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = ERROR;
         end
      endcase

      in_ready_d  = (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
      cpu_reset_d = (state_d != RUN);
      done_d      = (state_d == RUN);
      error_d     = (state_d == ERROR);
   end

   // State, counters and all externally visible outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= HDR;
         widx_q      <= '0;
         n_q         <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         in_ready_q  <= 1'b1;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= 32'd0;
`endif
      end else begin
         state_q     <= state_d;
         widx_q      <= widx_d;
         n_q         <= n_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         in_ready_q  <= in_ready_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_reset = cpu_reset_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule
